// File: rtl/div_ctrl_if.sv
// Divider handshake bundle between the E-stage pipeline and div_ctrl.
// The pipeline drives operands, start and cancel. The divider returns
// stall, the valid strobe and the HI/LO result.
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             div_startE;
  logic             div_signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             cancelE;
  logic             div_stallE;
  logic             div_validE;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output div_startE, div_signedE, srcaE, srcbE, cancelE,
    input  div_stallE, div_validE, hi_o, lo_o
  );

  modport slave (
    input  div_startE, div_signedE, srcaE, srcbE, cancelE,
    output div_stallE, div_validE, hi_o, lo_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider controller for the E stage (DIV / DIVU).
// The divider runs one shift-subtract step per cycle on operand magnitudes.
// Signs are applied when the result is captured: the quotient is negated
// when the operand signs differ, and the remainder follows the dividend.
// A zero divisor returns hi = dividend and lo = all ones.
// Build option: define DIV_ZERO_FAST_EN to skip the iterations for a zero
// divisor (IDLE goes straight to DONE).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting; a start without cancel latches operands and stalls
//   BUSY  | one restoring iteration per cycle, WIDTH cycles, stall high
//   DONE  | one-cycle valid strobe with the final HI/LO, then IDLE
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType state;
  stateType nextState;

  logic             accept;
  logic             stall;
  logic             valid;
  logic             lastIter;
  logic             fastZero;

  logic [CW-1:0]    iterCnt;
  logic [WIDTH-1:0] dividendRaw;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic             negQuo;
  logic             negRem;
  logic             divZero;

  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;
  logic [WIDTH-1:0] holdHi;
  logic [WIDTH-1:0] holdLo;

  logic [WIDTH-1:0] srcaMag;
  logic [WIDTH-1:0] srcbMag;
  logic             srcbZero;
  logic             srcaNeg;
  logic             srcbNeg;

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trialDiff;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;
  logic [WIDTH-1:0] finHi;
  logic [WIDTH-1:0] finLo;

  // Operand sign and magnitude. The most-negative value maps onto itself,
  // and read as unsigned that is exactly 2^(WIDTH-1).
  assign srcaNeg  = bus.div_signedE & bus.srcaE[WIDTH-1];
  assign srcbNeg  = bus.div_signedE & bus.srcbE[WIDTH-1];
  assign srcaMag  = srcaNeg ? (-bus.srcaE) : bus.srcaE;
  assign srcbMag  = srcbNeg ? (-bus.srcbE) : bus.srcbE;
  assign srcbZero = (bus.srcbE == '0);

`ifdef DIV_ZERO_FAST_EN
  assign fastZero = srcbZero;
`else
  assign fastZero = 1'b0;
`endif

  assign lastIter = (iterCnt == CW'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, then keep the
  // difference only if it did not go negative.
  always_comb begin
    remShift  = {remReg, quoReg[WIDTH-1]};
    trialDiff = remShift - {1'b0, divisorMag};
    nextRem   = remShift[WIDTH-1:0];
    nextQuo   = {quoReg[WIDTH-2:0], 1'b0};
    if (!trialDiff[WIDTH]) begin
      nextRem = trialDiff[WIDTH-1:0];
      nextQuo = {quoReg[WIDTH-2:0], 1'b1};
    end
  end

  // Signed fix-up and zero-divisor override of the final magnitudes.
  always_comb begin
    finLo = negQuo ? (-nextQuo) : nextQuo;
    finHi = negRem ? (-nextRem) : nextRem;
    if (divZero) begin
      finLo = '1;
      finHi = dividendRaw;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs. Cancel beats both start and DONE.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    stall     = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.div_startE && !bus.cancelE) begin
          accept    = 1'b1;
          stall     = 1'b1;
          nextState = fastZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.cancelE) begin
          nextState = IDLE;
        end else begin
          stall = 1'b1;
          if (lastIter) begin
            nextState = DONE;
          end
        end
      end
      DONE: begin
        valid     = !bus.cancelE;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and final-result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      iterCnt     <= '0;
      dividendRaw <= '0;
      divisorMag  <= '0;
      remReg      <= '0;
      quoReg      <= '0;
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
      divZero     <= 1'b0;
      resHi       <= '0;
      resLo       <= '0;
    end else if (accept) begin
      iterCnt     <= '0;
      dividendRaw <= bus.srcaE;
      divisorMag  <= srcbMag;
      remReg      <= '0;
      quoReg      <= srcaMag;
      negQuo      <= srcaNeg ^ srcbNeg;
      negRem      <= srcaNeg;
      divZero     <= srcbZero;
      if (fastZero) begin
        resHi <= bus.srcaE;
        resLo <= '1;
      end
    end else if (state == BUSY && !bus.cancelE) begin
      remReg  <= nextRem;
      quoReg  <= nextQuo;
      iterCnt <= iterCnt + 1'b1;
      if (lastIter) begin
        resHi <= finHi;
        resLo <= finLo;
      end
    end
  end

  // Keep the last delivered result. A DONE that was cancelled never
  // becomes visible outside DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdHi <= '0;
      holdLo <= '0;
    end else if (valid) begin
      holdHi <= resHi;
      holdLo <= resLo;
    end
  end

  assign bus.div_stallE = stall;
  assign bus.div_validE = valid;
  assign bus.hi_o       = (state == DONE) ? resHi : holdHi;
  assign bus.lo_o       = (state == DONE) ? resLo : holdLo;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl. Cycle 0 of each divide is the cycle in which
// start is presented to an IDLE divider.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(32)) bus ();

  div_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  // Advance to the next cycle; inputs are driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkSV(input string tag, input logic expStall, input logic expValid);
    chk({tag, " stall/valid"}, {30'd0, bus.div_stallE, bus.div_validE},
        {30'd0, expStall, expValid});
  endtask

  // Start is held through the stall and through DONE, where it must be ignored.
  task automatic runDiv(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expLo,
                        input logic [31:0] expHi, input int vCyc, input bit idleChk);
    step();
    bus.div_startE  = 1'b1;
    bus.div_signedE = sgn;
    bus.srcaE       = a;
    bus.srcbE       = b;
    #1;
    chkSV({tag, " c0"}, 1'b1, 1'b0);
    for (int c = 1; c < vCyc; c++) begin
      step();
      #1;
      chkSV($sformatf("%s c%0d", tag, c), 1'b1, 1'b0);
    end
    step();
    #1;
    chkSV({tag, " done"}, 1'b0, 1'b1);
    chk({tag, " lo"}, bus.lo_o, expLo);
    chk({tag, " hi"}, bus.hi_o, expHi);
    if (idleChk) begin
      step();
      bus.div_startE = 1'b0;
      #1;
      chkSV({tag, " idle"}, 1'b0, 1'b0);
      chk({tag, " lo hold"}, bus.lo_o, expLo);
      chk({tag, " hi hold"}, bus.hi_o, expHi);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.div_startE  = 1'b0;
    bus.div_signedE = 1'b0;
    bus.srcaE       = '0;
    bus.srcbE       = '0;
    bus.cancelE     = 1'b0;

    repeat (3) step();
    #1;
    chkSV("reset", 1'b0, 1'b0);
    chk("reset lo", bus.lo_o, 32'h0);
    chk("reset hi", bus.hi_o, 32'h0);
    rst = 1'b0;

    runDiv("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);
    runDiv("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 1'b1);
    runDiv("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33, 1'b1);
    runDiv("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, 1'b1);
    runDiv("divu min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b1);
    runDiv("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZLAT, 1'b1);
    runDiv("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, ZLAT, 1'b1);

    // Back-to-back: the second start arrives in the cycle after DONE.
    runDiv("b2b 1000/10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33, 1'b0);
    runDiv("b2b 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b1);

    // Cancel at cycle 10 of BUSY.
    step();
    bus.div_startE  = 1'b1;
    bus.div_signedE = 1'b0;
    bus.srcaE       = 32'd50;
    bus.srcbE       = 32'd5;
    #1;
    chkSV("cnl c0", 1'b1, 1'b0);
    for (int c = 1; c < 10; c++) begin
      step();
      #1;
      chkSV($sformatf("cnl c%0d", c), 1'b1, 1'b0);
    end
    step();
    bus.cancelE    = 1'b1;
    bus.div_startE = 1'b0;
    #1;
    chkSV("cnl c10", 1'b0, 1'b0);
    step();
    bus.cancelE = 1'b0;
    #1;
    chkSV("cnl c11", 1'b0, 1'b0);
    chk("cnl lo hold", bus.lo_o, 32'd3);
    chk("cnl hi hold", bus.hi_o, 32'd0);
    for (int c = 12; c < 40; c++) begin
      step();
      #1;
      chkSV($sformatf("cnl quiet c%0d", c), 1'b0, 1'b0);
    end

    // Cancel together with start in IDLE: nothing starts.
    step();
    bus.div_startE = 1'b1;
    bus.cancelE    = 1'b1;
    #1;
    chkSV("cnl idle", 1'b0, 1'b0);
    step();
    bus.div_startE = 1'b0;
    bus.cancelE    = 1'b0;
    #1;
    chkSV("cnl idle next", 1'b0, 1'b0);

    // Cancel in DONE: no valid, and the held result is not replaced.
    step();
    bus.div_startE = 1'b1;
    bus.srcaE      = 32'd20;
    bus.srcbE      = 32'd4;
    #1;
    chkSV("cnl done c0", 1'b1, 1'b0);
    for (int c = 1; c < 33; c++) begin
      step();
      #1;
      chkSV($sformatf("cnl done c%0d", c), 1'b1, 1'b0);
    end
    step();
    bus.cancelE = 1'b1;
    #1;
    chkSV("cnl done c33", 1'b0, 1'b0);
    step();
    bus.cancelE    = 1'b0;
    bus.div_startE = 1'b0;
    #1;
    chkSV("cnl done c34", 1'b0, 1'b0);
    chk("cnl done lo hold", bus.lo_o, 32'd3);
    chk("cnl done hi hold", bus.hi_o, 32'd0);

    // Reset at cycle 20 of a divide.
    step();
    bus.div_startE = 1'b1;
    bus.srcaE      = 32'd100;
    bus.srcbE      = 32'd7;
    #1;
    chkSV("rst c0", 1'b1, 1'b0);
    for (int c = 1; c < 20; c++) step();
    step();
    rst            = 1'b1;
    bus.div_startE = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chkSV("rst c21", 1'b0, 1'b0);
    chk("rst c21 lo", bus.lo_o, 32'h0);
    chk("rst c21 hi", bus.hi_o, 32'h0);

    // A start that coincides with reset is dropped.
    step();
    rst            = 1'b1;
    bus.div_startE = 1'b1;
    bus.srcaE      = 32'd9;
    bus.srcbE      = 32'd3;
    step();
    rst            = 1'b0;
    bus.div_startE = 1'b0;
    #1;
    chkSV("rst+start", 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      step();
      #1;
      chkSV($sformatf("rst+start quiet %0d", c), 1'b0, 1'b0);
    end
    chk("rst+start lo", bus.lo_o, 32'h0);
    chk("rst+start hi", bus.hi_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
